ysyx_25040109_trap_seq: RTL and testbench
=========================================

// Module: ysyx_25040109_trap_seq
// PURPOSE
//  Trap/CSR sequencer directly upstream of ysyx_25040109_RegisterFile's single CSR write port.
//  Accepts one system instruction (ECALL, MRET, CSRRW/CSRRS/CSRRC) from execute.
//  Serialises its CSR updates (mepc, mcause, mstatus) one write per cycle.
//  Writes old CSR values to rd and issues the PC redirect.
// PARAMETERS
//  DATA_WIDTH   32     CSR/GPR data width
//  ECALL_CAUSE  32'd11 mcause value written by ECALL (environment call from M-mode)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous, active-low reset
//  in_valid     in   1   execute presents a system instruction
//  in_ready     out  1   sequencer can accept (IDLE only)
//  op           in   3   0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, others illegal
//  in_pc        in   32  PC of the instruction
//  in_csr_addr  in   12  CSR address (CSR ops)
//  in_rs1_idx   in   5   rs1 index (x0 suppresses CSRRS/CSRRC write)
//  in_rs1_val   in   32  rs1 value
//  in_rd        in   5   destination GPR
//  csr_rdata    in   32  combinational read data from register file for csr_addr
//  mepc_in      in   32  current mepc
//  mtvec_in     in   32  current mtvec
//  csr_we       out  1   CSR write enable to register file
//  csr_addr     out  12  CSR address (read and write)
//  csr_wdata    out  32  CSR write data
//  gpr_wen      out  1   rd write enable; gpr_waddr out 5; gpr_wdata out 32
//  redir_valid  out  1   one-cycle pulse: fetch must load redir_pc
//  redir_pc     out  32  redirect target
//  done         out  1   one-cycle pulse: instruction retired
// BEHAVIOUR
//  - Reset (rst=0, any time, incl. mid-sequence): state IDLE, latched fields 0, all outputs 0 except in_ready=1.
//    No partial sequence resumes after reset.
//  - Handshake: accept when in_valid&&in_ready; latch op/pc/addr/rs1/rd that edge; in_ready=0 until back in IDLE.
//  - FSM states: IDLE, CSR, EPC, CAUSE, STAT_E, STAT_M, REDIR.
//  - CSR op: IDLE->CSR->IDLE.
//    In CSR: csr_addr=latched addr; gpr_wen=(rd!=0), gpr_wdata=csr_rdata (old value).
//    csr_wdata = RW: rs1 | RS: old|rs1 | RC: old&~rs1.
//    csr_we=1 except RS/RC with rs1_idx==0.
//    done=1, no redirect. Latency 1 cycle after accept.
//  - ECALL: IDLE->EPC->CAUSE->STAT_E->REDIR->IDLE.
//    EPC writes mepc=pc. CAUSE writes mcause=ECALL_CAUSE.
//    STAT_E writes mstatus = old with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
//    REDIR: redir_valid=1, redir_pc=mtvec_in, done=1. done 4 cycles after accept.
//  - MRET: IDLE->STAT_M->REDIR->IDLE.
//    STAT_M writes mstatus = old with MIE=MPIE, MPIE=1, MPP=2'b11 (M-only core).
//    REDIR target = mepc_in. done 2 cycles after accept.
//  - csr_rdata is combinational from csr_addr; sequencer drives csr_addr=0x300 in STAT_x states.
//  - Registered outputs, one CSR write per cycle maximum.
//  - Illegal op accepted: go IDLE next cycle, done=1, no writes, no redirect.
//  - Unimplemented CSR address: write still issued (register file drops it); rd receives csr_rdata (0).
//  - in_valid while busy: ignored (in_ready=0); upstream holds the instruction.
//  - mtvec/mepc sampled in REDIR, so an ECALL sees the mepc it just wrote.
// STRUCTURE
//  - Shared package ysyx_25040109_csr_pkg: CSR addresses (0x300/0x305/0x341/0x342),
//    mstatus bit positions MIE=3, MPIE=7, MPP=12:11, op encoding, FSM state enum.
//  - One sub-module ysyx_25040109_csr_alu: combinational RW/RS/RC new-value computation.
//  - FSM and output registers stay in this file.
// TESTING
//  - Reset: rst low mid-ECALL (in CAUSE) -> next edge all outputs 0, in_ready=1; no further csr_we.
//  - CSRRW: csr 0x305, rs1=x5=0x80000100, old 0, rd=x6 -> 1 cycle later:
//    csr_we, wdata 0x80000100, gpr_wen x6=0, done.
//  - CSRRS x0: rs1_idx=0, mstatus=0x1800 -> csr_we=0, x(rd)=0x1800, done.
//  - ECALL: pc=0x80000040, mtvec=0x80000200, mstatus=0x1808 -> writes mepc=0x80000040, mcause=11,
//    mstatus=0x1880 on consecutive cycles; redir 0x80000200 at cycle 4.
//  - MRET: mstatus=0x1880, mepc=0x80000044 -> mstatus=0x1888; redir_pc=0x80000044 at cycle 2.
//  - Back-to-back: in_valid held across ECALL -> second accept only the cycle after done; illegal op 7 -> done, no writes.

Source files
------------

// File: rtl/ysyx_25040109_csr_pkg.sv
// Shared CSR constants, system-op encoding and trap sequencer state enum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25040109_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } sys_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CSR    = 3'd1,
    ST_EPC    = 3'd2,
    ST_CAUSE  = 3'd3,
    ST_STAT_E = 3'd4,
    ST_STAT_M = 3'd5,
    ST_REDIR  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/ysyx_25040109_trap_seq_if.sv
// Execute -> trap sequencer request channel (one system instruction per handshake).
// Latency: n/a (wires only).
// Backpressure: in_ready low while the sequencer is busy; master holds the request.
interface ysyx_25040109_trap_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [11:0]           in_csr_addr;
  logic [4:0]            in_rs1_idx;
  logic [DATA_WIDTH-1:0] in_rs1_val;
  logic [4:0]            in_rd;

  modport master (
    output in_valid, op, in_pc, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, in_pc, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd,
    output in_ready
  );
endinterface

// File: rtl/ysyx_25040109_csr_alu.sv
// New CSR value for CSRRW/CSRRS/CSRRC from the old value and rs1.
// Latency: combinational.
// Backpressure: none.
module ysyx_25040109_csr_alu
  import ysyx_25040109_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  output logic [DATA_WIDTH-1:0] new_val
);

  // Set/clear merge rs1 into the old value; anything else is a plain swap.
  always_comb begin
    new_val = rs1_val;
    case (op)
      OP_CSRRS: new_val = old_val | rs1_val;
      OP_CSRRC: new_val = old_val & ~rs1_val;
      default:  new_val = rs1_val;
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_trap_seq.sv
// Trap/CSR sequencer: serialises ECALL/MRET/CSRRx CSR writes, writes old CSR to rd, redirects PC.
// Latency: CSRRx 1 cycle, MRET 2, ECALL 4, illegal 1 (done pulse) after accept.
// Backpressure: in_ready only in IDLE; requests arriving while busy are held upstream.
module ysyx_25040109_trap_seq
  import ysyx_25040109_csr_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = DATA_WIDTH'(11)
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25040109_trap_seq_if.slave req,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  gpr_wen,
  output logic [4:0]            gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  redir_valid,
  output logic [DATA_WIDTH-1:0] redir_pc,
  output logic                  done
);

  seq_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
  logic                  in_ready_q, in_ready_d;
  logic                  csr_we_q, csr_we_d;
  logic [11:0]           csr_addr_q, csr_addr_d;
  logic                  gpr_wen_q, gpr_wen_d;
  logic [4:0]            gpr_waddr_q, gpr_waddr_d;
  logic                  redir_valid_q, redir_valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] alu_wdata;
  logic [DATA_WIDTH-1:0] mstatus_new;

  ysyx_25040109_csr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_csr_alu (
    .op      (op_q),
    .old_val (csr_rdata),
    .rs1_val (rs1_val_q),
    .new_val (alu_wdata)
  );

  // Next state plus the control outputs that belong to the state being entered.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_d          = pc_q;
    rs1_val_d     = rs1_val_q;
    csr_we_d      = 1'b0;
    csr_addr_d    = '0;
    gpr_wen_d     = 1'b0;
    gpr_waddr_d   = '0;
    redir_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.in_valid && in_ready_q) begin
          op_d      = req.op;
          pc_d      = req.in_pc;
          rs1_val_d = req.in_rs1_val;
          case (req.op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
              state_d     = ST_CSR;
              csr_addr_d  = req.in_csr_addr;
              // rs1 = x0 turns set/clear into a pure read.
              csr_we_d    = (req.op == OP_CSRRW) || (req.in_rs1_idx != 5'd0);
              gpr_wen_d   = (req.in_rd != 5'd0);
              gpr_waddr_d = req.in_rd;
              done_d      = 1'b1;
            end
            OP_ECALL: begin
              state_d    = ST_EPC;
              csr_addr_d = CSR_MEPC;
              csr_we_d   = 1'b1;
            end
            OP_MRET: begin
              state_d    = ST_STAT_M;
              csr_addr_d = CSR_MSTATUS;
              csr_we_d   = 1'b1;
            end
            // Illegal op retires immediately with no side effects.
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_CSR:   state_d = ST_IDLE;
      ST_EPC: begin
        state_d    = ST_CAUSE;
        csr_addr_d = CSR_MCAUSE;
        csr_we_d   = 1'b1;
      end
      ST_CAUSE: begin
        state_d    = ST_STAT_E;
        csr_addr_d = CSR_MSTATUS;
        csr_we_d   = 1'b1;
      end
      ST_STAT_E, ST_STAT_M: begin
        state_d       = ST_REDIR;
        redir_valid_d = 1'b1;
        done_d        = 1'b1;
      end
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, latched instruction fields and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      pc_q          <= '0;
      rs1_val_q     <= '0;
      in_ready_q    <= 1'b1;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      gpr_wen_q     <= 1'b0;
      gpr_waddr_q   <= '0;
      redir_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      pc_q          <= pc_d;
      rs1_val_q     <= rs1_val_d;
      in_ready_q    <= in_ready_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      gpr_wen_q     <= gpr_wen_d;
      gpr_waddr_q   <= gpr_waddr_d;
      redir_valid_q <= redir_valid_d;
      done_q        <= done_d;
    end
  end

  // Write data depends on the old CSR value read back through csr_addr this
  // same cycle, so it is muxed live and gated by the registered write enable.
  always_comb begin
    mstatus_new = csr_rdata;
    case (state_q)
      ST_STAT_E: begin
        mstatus_new[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
        mstatus_new[MSTATUS_MIE]                   = 1'b0;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      ST_STAT_M: begin
        mstatus_new[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
        mstatus_new[MSTATUS_MPIE]                  = 1'b1;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      default: mstatus_new = csr_rdata;
    endcase

    csr_wdata = '0;
    if (csr_we_q) begin
      case (state_q)
        ST_CSR:               csr_wdata = alu_wdata;
        ST_EPC:               csr_wdata = pc_q;
        ST_CAUSE:             csr_wdata = ECALL_CAUSE;
        ST_STAT_E, ST_STAT_M: csr_wdata = mstatus_new;
        default:              csr_wdata = '0;
      endcase
    end
  end

  assign req.in_ready = in_ready_q;
  assign csr_we       = csr_we_q;
  assign csr_addr     = csr_addr_q;
  assign gpr_wen      = gpr_wen_q;
  assign gpr_waddr    = gpr_waddr_q;
  assign gpr_wdata    = gpr_wen_q ? csr_rdata : '0;
  assign redir_valid  = redir_valid_q;
  // Target is sampled in REDIR so an ECALL sees the mepc it just wrote.
  assign redir_pc     = redir_valid_q ? ((op_q == OP_MRET) ? mepc_in : mtvec_in) : '0;
  assign done         = done_q;

endmodule

// File: tb/tb_ysyx_25040109_trap_seq.sv
// Directed + random bench for the trap sequencer against a CSR-level reference model.
module tb_ysyx_25040109_trap_seq;

  logic        clk;
  logic        rst;
  logic [31:0] csr_rdata, mepc_in, mtvec_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        done;

  int errors = 0;
  int checks = 0;
  int ninstr = 0;

  // CSR register file environment (only these addresses exist).
  logic [31:0] rf [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_val;
  // Reference model CSR state.
  logic [31:0] m [4096];
  logic [11:0] impl_list [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
  logic [11:0] rnd_addr  [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};

  ysyx_25040109_trap_seq_if #(.DATA_WIDTH(32)) ifc ();

  ysyx_25040109_trap_seq dut (
    .clk         (clk),
    .rst         (rst),
    .req         (ifc),
    .csr_rdata   (csr_rdata),
    .mepc_in     (mepc_in),
    .mtvec_in    (mtvec_in),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .gpr_wen     (gpr_wen),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit impl(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic logic [31:0] mrd(input logic [11:0] a);
    return impl(a) ? m[a] : 32'h0;
  endfunction

  assign csr_rdata = impl(csr_addr) ? rf[csr_addr] : 32'h0;
  assign mepc_in   = rf[12'h341];
  assign mtvec_in  = rf[12'h305];

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_val;
    else if (csr_we && impl(csr_addr)) rf[csr_addr] <= csr_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int c, input string name);
    return $sformatf("i%0d_c%0d_%s", ninstr, c, name);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    check({tag, "_csr_we"}, 32'(csr_we), 32'd0);
    check({tag, "_csr_addr"}, 32'(csr_addr), 32'd0);
    check({tag, "_csr_wdata"}, csr_wdata, 32'd0);
    check({tag, "_gpr_wen"}, 32'(gpr_wen), 32'd0);
    check({tag, "_gpr_waddr"}, 32'(gpr_waddr), 32'd0);
    check({tag, "_gpr_wdata"}, gpr_wdata, 32'd0);
    check({tag, "_redir_valid"}, 32'(redir_valid), 32'd0);
    check({tag, "_redir_pc"}, redir_pc, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Preset one CSR in both the environment and the model; starts and ends at a negedge.
  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    pre_addr = a;
    pre_val  = v;
    pre_we   = 1'b1;
    m[a]     = v;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic check_csrs(input string tag);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_csr%h", tag, impl_list[k]), rf[impl_list[k]], m[impl_list[k]]);
  endtask

  // Issue one instruction (called just after a negedge) and check every cycle until idle.
  task automatic run_instr(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] addr,
                           input logic [4:0] rs1i, input logic [31:0] rs1v, input logic [4:0] rd,
                           input bit hold);
    int          lat, nw, w;
    logic [11:0] wa [3];
    logic [31:0] wd [3];
    bit          gw, rv, ill;
    logic [31:0] gd, rpc, old, nv, ms;
    ninstr++;
    ifc.op = op; ifc.in_pc = pc; ifc.in_csr_addr = addr;
    ifc.in_rs1_idx = rs1i; ifc.in_rs1_val = rs1v; ifc.in_rd = rd;
    ifc.in_valid = 1'b1;
    w = 0;
    while (ifc.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check(tg(0, "accept_wait"), 32'(w), 32'd0);

    nw = 0; gw = 0; rv = 0; ill = 0; gd = 0; rpc = 0; lat = 1;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        old = mrd(addr);
        nv  = (op == 3'd0) ? rs1v : (op == 3'd1) ? (old | rs1v) : (old & ~rs1v);
        gw  = (rd != 5'd0);
        gd  = old;
        if (op == 3'd0 || rs1i != 5'd0) begin
          wa[0] = addr; wd[0] = nv; nw = 1;
          if (impl(addr)) m[addr] = nv;
        end
      end
      3'd3: begin
        ms = m[12'h300];
        ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
        wa[0] = 12'h341; wd[0] = pc;
        wa[1] = 12'h342; wd[1] = 32'd11;
        wa[2] = 12'h300; wd[2] = ms;
        nw = 3; lat = 4; rv = 1;
        m[12'h341] = pc; m[12'h342] = 32'd11; m[12'h300] = ms;
        rpc = m[12'h305];
      end
      3'd4: begin
        ms = m[12'h300];
        ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
        wa[0] = 12'h300; wd[0] = ms;
        nw = 1; lat = 2; rv = 1;
        m[12'h300] = ms;
        rpc = m[12'h341];
      end
      default: ill = 1;
    endcase

    @(posedge clk);
    #1;
    if (!hold) ifc.in_valid = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check(tg(c, "csr_we"), 32'(csr_we), 32'(c <= nw));
      if (c <= nw) begin
        check(tg(c, "csr_addr"), 32'(csr_addr), 32'(wa[c-1]));
        check(tg(c, "csr_wdata"), csr_wdata, wd[c-1]);
      end
      check(tg(c, "gpr_wen"), 32'(gpr_wen), 32'(gw && c == 1));
      if (gw && c == 1) begin
        check(tg(c, "gpr_waddr"), 32'(gpr_waddr), 32'(rd));
        check(tg(c, "gpr_wdata"), gpr_wdata, gd);
      end
      check(tg(c, "done"), 32'(done), 32'(c == lat));
      check(tg(c, "redir_valid"), 32'(redir_valid), 32'(rv && c == lat));
      if (rv && c == lat) check(tg(c, "redir_pc"), redir_pc, rpc);
      check(tg(c, "in_ready"), 32'(ifc.in_ready), 32'(ill || c == lat + 1));
    end
    check_csrs(tg(lat + 1, "state"));
  endtask

  initial begin
    rst = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_val = '0;
    ifc.in_valid = 1'b0; ifc.op = '0; ifc.in_pc = '0; ifc.in_csr_addr = '0;
    ifc.in_rs1_idx = '0; ifc.in_rs1_val = '0; ifc.in_rd = '0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    set_csr(12'h300, 32'h0000_1808);
    set_csr(12'h305, 32'h8000_0200);
    set_csr(12'h340, 32'h0);
    set_csr(12'h341, 32'h0);
    set_csr(12'h342, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted while an ECALL sits in CAUSE: mepc already written, nothing after.
    ifc.op = 3'd3; ifc.in_pc = 32'h8000_0080; ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_cause_we", 32'(csr_we), 32'd1);
    check("rst_mid_cause_addr", 32'(csr_addr), 32'h342);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    m[12'h341] = 32'h8000_0080;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_c%0d_we", c), 32'(csr_we), 32'd0);
      check($sformatf("rst_after_c%0d_done", c), 32'(done), 32'd0);
    end
    check_csrs("rst_after");

    // CSRRW mtvec, old 0, rs1=x5.
    set_csr(12'h305, 32'h0);
    run_instr(3'd0, 32'h8000_0010, 12'h305, 5'd5, 32'h8000_0100, 5'd6, 1'b0);
    check("csrrw_mtvec", rf[12'h305], 32'h8000_0100);

    // CSRRS with rs1=x0 reads mstatus without writing.
    set_csr(12'h305, 32'h8000_0200);
    set_csr(12'h300, 32'h0000_1800);
    run_instr(3'd1, 32'h8000_0014, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd7, 1'b0);
    check("csrrs_x0_mstatus", rf[12'h300], 32'h0000_1800);

    // ECALL then MRET.
    set_csr(12'h300, 32'h0000_1808);
    run_instr(3'd3, 32'h8000_0040, 12'h0, 5'd0, 32'h0, 5'd0, 1'b0);
    check("ecall_mstatus", rf[12'h300], 32'h0000_1880);
    check("ecall_mepc", rf[12'h341], 32'h8000_0040);
    set_csr(12'h341, 32'h8000_0044);
    run_instr(3'd4, 32'h8000_0200, 12'h0, 5'd0, 32'h0, 5'd0, 1'b0);
    check("mret_mstatus", rf[12'h300], 32'h0000_1888);

    // in_valid held across ECALL: next accept right after done.
    run_instr(3'd3, 32'h8000_0050, 12'h0, 5'd0, 32'h0, 5'd0, 1'b1);
    run_instr(3'd3, 32'h8000_0050, 12'h0, 5'd0, 32'h0, 5'd0, 1'b0);

    // Illegal op and an unimplemented CSR.
    run_instr(3'd7, 32'h8000_0060, 12'h300, 5'd1, 32'h1234_5678, 5'd9, 1'b0);
    run_instr(3'd0, 32'h8000_0064, 12'h7C0, 5'd2, 32'hDEAD_BEEF, 5'd3, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  rop;
      logic [4:0]  rs1i, rd;
      rop  = 3'($urandom_range(0, 7));
      rs1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_instr(rop, $urandom, rnd_addr[$urandom_range(0, 5)], rs1i, $urandom, rd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
